// File: rtl/forward_ctrl_pkg.sv
// Shared definitions for the forwarding controller: select encodings,
// Tnew constants, the pipeline stage record and the nearest-first search.
package forward_ctrl_pkg;

  // D-stage selects; FWD_PIPE means "take the pipeline register value".
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_E    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b11;
  localparam logic [1:0] FWD_PIPE = 2'b00;
  // E-stage selects use a shifted encoding because E never forwards from itself.
  localparam logic [1:0] FWDE_M   = 2'b01;
  localparam logic [1:0] FWDE_W   = 2'b10;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       regwrite;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_rec_t;

  function automatic logic src_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
    return (src != 5'd0) && (src == dst) && we;
  endfunction

  // Nearest producer wins; a pending result there blocks any older copy.
  function automatic logic [1:0] sel_d(input logic [4:0] src,
                                       input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                       input logic e_we,
                                       input logic [4:0] m_dst, input logic [1:0] m_tnew,
                                       input logic m_we,
                                       input logic [4:0] w_dst, input logic w_we);
    if (src_match(src, e_dst, e_we))      return (e_tnew == 2'd0) ? FWD_E : FWD_RF;
    else if (src_match(src, m_dst, m_we)) return (m_tnew == 2'd0) ? FWD_M : FWD_RF;
    else if (src_match(src, w_dst, w_we)) return FWD_W;
    else                                  return FWD_RF;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] src,
                                       input logic [4:0] m_dst, input logic [1:0] m_tnew,
                                       input logic m_we,
                                       input logic [4:0] w_dst, input logic w_we);
    if (src_match(src, m_dst, m_we))      return (m_tnew == 2'd0) ? FWDE_M : FWD_PIPE;
    else if (src_match(src, w_dst, w_we)) return FWDE_W;
    else                                  return FWD_PIPE;
  endfunction

endpackage

// File: rtl/forward_ctrl_stage_reg.sv
// One pipeline stage record: async reset, bubble clear and write-enable mask.
module fwd_stage_reg
  import forward_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       we_mask,
  input  stage_rec_t d,
  output stage_rec_t q
);

  stage_rec_t next_rec;

  always_comb begin
    next_rec          = d;
    next_rec.regwrite = d.regwrite & we_mask;
    if (clear) next_rec = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= next_rec;
  end

endmodule

// File: rtl/forward_ctrl.sv
// Tracks in-flight register writes through E/M/W and drives the D, E and M
// forwarding selects plus the producer records consumed by the stall unit.
module forward_ctrl
  import forward_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] dst_D,
  input  logic [1:0] tnew_D,
  input  logic       regwrite_D,
  input  logic       cond_fail_E,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M,
  output logic [4:0] dst_E,
  output logic [4:0] dst_M,
  output logic [1:0] tnew_E,
  output logic [1:0] tnew_M,
  output logic       regwrite_E,
  output logic       regwrite_M
);

  stage_rec_t rec_d, rec_e, rec_m, rec_w;
  stage_rec_t to_m, to_w;
  logic       we_e;
  logic       unused_bits;

  assign rec_d = '{dst: dst_D, tnew: tnew_D, regwrite: regwrite_D, rs: rs_D, rt: rt_D};
  assign we_e  = rec_e.regwrite & ~cond_fail_E & (rec_e.dst != 5'd0);

  // M keeps only rt (store data); W keeps no sources and always has Tnew 0.
  always_comb begin
    to_m      = '0;
    to_m.dst  = rec_e.dst;
    to_m.tnew = (rec_e.tnew == 2'd0) ? 2'd0 : rec_e.tnew - 2'd1;
    to_m.regwrite = rec_e.regwrite;
    to_m.rt   = rec_e.rt;
    to_w      = '0;
    to_w.dst  = rec_m.dst;
    to_w.regwrite = rec_m.regwrite;
  end

  fwd_stage_reg u_reg_e (.clk(clk), .reset(reset), .clear(stall), .we_mask(1'b1),
                         .d(rec_d), .q(rec_e));
  fwd_stage_reg u_reg_m (.clk(clk), .reset(reset), .clear(1'b0), .we_mask(we_e),
                         .d(to_m), .q(rec_m));
  fwd_stage_reg u_reg_w (.clk(clk), .reset(reset), .clear(1'b0), .we_mask(1'b1),
                         .d(to_w), .q(rec_w));

  assign fwd_rs_D = sel_d(rs_D, rec_e.dst, rec_e.tnew, we_e, rec_m.dst, rec_m.tnew,
                          rec_m.regwrite, rec_w.dst, rec_w.regwrite);
  assign fwd_rt_D = sel_d(rt_D, rec_e.dst, rec_e.tnew, we_e, rec_m.dst, rec_m.tnew,
                          rec_m.regwrite, rec_w.dst, rec_w.regwrite);
  assign fwd_rs_E = sel_e(rec_e.rs, rec_m.dst, rec_m.tnew, rec_m.regwrite,
                          rec_w.dst, rec_w.regwrite);
  assign fwd_rt_E = sel_e(rec_e.rt, rec_m.dst, rec_m.tnew, rec_m.regwrite,
                          rec_w.dst, rec_w.regwrite);
  assign fwd_rt_M = src_match(rec_m.rt, rec_w.dst, rec_w.regwrite);

  assign dst_E      = rec_e.dst;
  assign tnew_E     = rec_e.tnew;
  assign regwrite_E = we_e;
  assign dst_M      = rec_m.dst;
  assign tnew_M     = rec_m.tnew;
  assign regwrite_M = rec_m.regwrite;

  assign unused_bits = ^{rec_m.rs, rec_w.rs, rec_w.rt, rec_w.tnew};

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Producer-side companion to the pipeline stall unit. Tracks every in-flight register write (destination, Tnew, write-enable) through the E, M and W stages, and generates the forwarding-mux selects that deliver results back to consumers in D, E and M. It also exports per-stage producer records (dst/Tnew/regwrite for E and M) that the stall unit consumes, so both blocks share one timing model.

## Interface
Parameters
- none: the register file is fixed at 32 x 32-bit, and register 0 is never a forwarding target.

Ports
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all stage records
- stall  in  1  from stall unit; D holds, E receives a bubble
- rs_D, rt_D  in  5  source register numbers of the instruction in D (0 = not used)
- dst_D  in  5  destination register of the instruction in D (0 = no write)
- tnew_D  in  2  cycles after entering E until the result exists (ALU=1, load=2, link=0)
- regwrite_D  in  1  instruction in D writes the register file
- cond_fail_E  in  1  conditional-write instruction in E evaluated false (for example, a branch-and-link whose condition failed)
- fwd_rs_D, fwd_rt_D  out  2  D-stage select: 00 RF, 01 E, 10 M, 11 W
- fwd_rs_E, fwd_rt_E  out  2  E-stage select: 00 ID/EX register, 01 M, 10 W
- fwd_rt_M  out  1  M-stage store data: 0 EX/MEM register, 1 W
- dst_E, dst_M  out  5  destination of the record in E and M
- tnew_E, tnew_M  out  2  remaining Tnew of the record in E and M
- regwrite_E, regwrite_M  out  1  effective write-enable of the record in E and M

## Operation
- Stage record = {dst, tnew, regwrite, rs, rt}. E, M and W each hold one record; rs/rt are kept only where a consumer needs them (E: rs, rt; M: rt).
- Effective E write-enable: weE = regwrite_E_reg & ~cond_fail_E & (dst_E ≠ 0). The regwrite_E output equals weE.
- Record advance, every rising edge:
  - W ← M.
  - M ← E, with regwrite = weE and tnew = max(tnew_E − 1, 0).
  - E ← D record, or an all-zero bubble when stall = 1.
- Tnew of W is always 0. A producer with regwrite = 0 is never a match.
- A match at stage S for source r requires: r ≠ 0, r = dst_S, and write-enable_S = 1.
- D-stage select: search E, then M, then W, and stop at the first matching stage.
  - If tnew_S = 0 at that stage, select S.
  - Otherwise output 00. The stall unit covers this case.
  - A stale match in a farther stage must never be forwarded past a nearer pending producer.
- E-stage select: search M, then W, with the same nearest-first rule. A match at M with tnew_M > 0 outputs 00.
- fwd_rt_M = 1 iff rt_M ≠ 0, rt_M = dst_W and regwrite_W = 1.
- All select outputs are combinational from the current records, the D inputs and cond_fail_E. There are no registered outputs.

## Timing
- Reset (asynchronous): all records zero.
  - All selects are 00/0.
  - dst_E/dst_M are 0, tnew_E/tnew_M are 0, regwrite_E/regwrite_M are 0.
- Records update 1 cycle after presentation in D; a producer is visible in E outputs the cycle after it leaves D.
- Stall for N cycles inserts N bubbles into E. Records already in E and M keep advancing, so Tnew counts down during the stall.
- stall and cond_fail_E in the same cycle: E receives a bubble, and M receives the E record with regwrite = 0.
- Reset asserted mid-stream discards all in-flight records immediately, without waiting for a clock edge.

## Structure
- Shared package holds:
  - select encodings (FWD_RF, FWD_E, FWD_M, FWD_W, FWD_PIPE)
  - Tnew constants (TNEW_LINK = 0, TNEW_ALU = 1, TNEW_LOAD = 2)
  - the stage-record typedef
- One sub-module: fwd_stage_reg, a single record register with asynchronous reset, a clear input (bubble) and a write-enable mask. It is instantiated for E, M and W.

## Test plan
- ALU to ALU: add $3 (tnew 1), next instruction reads $3 in E. The following cycle fwd_rs_E = 01 (M); the cycle after, a reader in E gets 10 (W).
- Load-use: lw $5 (tnew 2) in E, consumer of $5 in D. fwd_rs_D = 00, tnew_E = 2. After one stall, tnew_M = 1 and fwd = 00. After the second stall, the record is in W and fwd_rs_D = 11.
- Nearest-first: $4 written by lw in E and by add in W. D reader of $4 gets 00, never 11.
- Register 0: dst = 0 with regwrite = 1 and a reader of $0. All selects stay 00.
- Conditional link: bgezal in E (dst 31, tnew 0) with cond_fail_E = 1. fwd_rs_D for $31 = 00, regwrite_E = 0, and the next cycle regwrite_M = 0.
- Reset mid-stream: load in M, asynchronous reset pulse. All outputs read 0 within the same cycle with no clock edge, and stay 0 until new records arrive.
